mem_access_unit: RTL and testbench

Load/store initiator for the multi-cycle CPU. It accepts one memory request at a time from the datapath control FSM and checks alignment and range. It then drives the data memory's `DMWr`/`MemRead`/`MemOp`/`MemEXT`/`address`/`din` port for exactly one access cycle, captures `dout` into an internal MDR, and returns a one-cycle response. Misaligned or out-of-range requests never reach the memory; they return a fault with the offending address, which feeds the exception logic.

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_align_check.sv | 34 +++
 rtl/mem_access_unit.sv | 88 ++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access path: access sizes, data base
// address and the load/store initiator FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] DATA_BASE_ADDRESS = 32'h0000_0000;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'b00,
    MAU_ACCESS = 2'b01,
    MAU_RESP   = 2'b10,
    MAU_FAULT  = 2'b11
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the data-memory port of the load/store unit.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_op;
  logic        req_ext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] rsp_badaddr;

  logic        DMWr;
  logic        MemRead;
  logic        MemEXT;
  logic [1:0]  MemOp;
  logic [31:0] address;
  logic [31:0] din;
  logic [31:0] dout;

  modport slave (
    input  req_valid, req_we, req_op, req_ext, req_addr, req_wdata, dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_badaddr,
           DMWr, MemRead, MemEXT, MemOp, address, din
  );

  modport master (
    output req_valid, req_we, req_op, req_ext, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_badaddr
  );

  modport mem (
    input  DMWr, MemRead, MemEXT, MemOp, address, din,
    output dout
  );

endinterface

// File: rtl/mem_align_check.sv
// Combinational range/alignment check for a data-memory byte address; shared
// with the instruction-fetch path.
module mem_align_check
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = DATA_BASE_ADDRESS,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic [31:0] addr,
  input  logic [1:0]  op,
  output logic        fault
);

  // 33 bits so a window reaching the top of the address space still compares correctly
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;

  logic [31:0] off;
  logic        range_bad;
  logic        align_bad;

  always_comb begin
    off       = addr - DATA_BASE;
    range_bad = ({1'b0, off} >= LIMIT);
    align_bad = 1'b0;
    case (op)
      MEM_BYTE: align_bad = 1'b0;
      MEM_HALF: align_bad = off[0];
      MEM_WORD: align_bad = (off[1:0] != 2'b00);
      default:  align_bad = 1'b1;
    endcase
    fault = range_bad | align_bad;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: accepts one request, checks it, runs a single memory
// access cycle, captures the load data into the MDR and returns a response pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = DATA_BASE_ADDRESS,
  parameter int unsigned MEM_WORDS = 1024
) (
  input logic            clk,
  input logic            rst,
  mem_access_unit_if.slave bus
);

  mau_state_e  state;
  mau_state_e  state_nxt;
  logic        a_we;
  logic        a_ext;
  logic [1:0]  a_op;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] mdr;
  logic        accept;
  logic        fault;

  mem_align_check #(
    .DATA_BASE (DATA_BASE),
    .MEM_WORDS (MEM_WORDS)
  ) u_check (
    .addr  (bus.req_addr),
    .op    (bus.req_op),
    .fault (fault)
  );

  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MAU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MAU_IDLE:   if (accept) state_nxt = fault ? MAU_FAULT : MAU_ACCESS;
      MAU_ACCESS: state_nxt = MAU_RESP;
      MAU_RESP:   state_nxt = MAU_IDLE;
      MAU_FAULT:  state_nxt = MAU_IDLE;
      default:    state_nxt = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_we    <= 1'b0;
      a_op    <= 2'b00;
      a_ext   <= 1'b0;
      a_addr  <= 32'h0;
      a_wdata <= 32'h0;
    end else if (accept) begin
      a_we    <= bus.req_we;
      a_op    <= bus.req_op;
      a_ext   <= bus.req_ext;
      a_addr  <= bus.req_addr;
      a_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      mdr <= 32'h0;
    else if (state == MAU_ACCESS) mdr <= a_we ? 32'h0 : bus.dout;
  end

  assign bus.req_ready = (state == MAU_IDLE) && !rst;

  // Strobes gated by rst so an in-flight write is withdrawn without waiting for an edge
  assign bus.DMWr    = (state == MAU_ACCESS) && a_we && !rst;
  assign bus.MemRead = (state == MAU_ACCESS) && !a_we && !rst;
  assign bus.address = a_addr;
  assign bus.MemOp   = a_op;
  assign bus.MemEXT  = a_ext;
  assign bus.din     = a_wdata;

  assign bus.rsp_valid   = (state == MAU_RESP) || (state == MAU_FAULT);
  assign bus.rsp_fault   = (state == MAU_FAULT);
  assign bus.rsp_rdata   = (state == MAU_RESP) ? mdr : 32'h0;
  assign bus.rsp_badaddr = (state == MAU_FAULT) ? a_addr : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts each
// response at issue time; a negedge monitor pops and compares every rsp_valid pulse.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] badaddr;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   neg_cnt = 0;
  int   rsp_cnt = 0;
  int   dmwr_cyc = 0;
  int   memread_cyc = 0;
  logic        last_fault = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_badaddr = 32'h0;
  exp_t q[$];

  logic [31:0] mem [0:1023] = '{default: '0};
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] word;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  mem_access_unit_if bus ();

  mem_access_unit #(
    .DATA_BASE (32'h0),
    .MEM_WORDS (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write committed on the falling edge, extended read data combinational
  always @(negedge clk) begin
    if (bus.DMWr) begin
      case (bus.MemOp)
        MEM_BYTE: mem[bus.address[11:2]][8*bus.address[1:0] +: 8] <= bus.din[7:0];
        MEM_HALF: mem[bus.address[11:2]][16*bus.address[1] +: 16] <= bus.din[15:0];
        default:  mem[bus.address[11:2]] <= bus.din;
      endcase
    end
  end

  always_comb begin
    word = mem[bus.address[11:2]];
    bsel = word[8*bus.address[1:0] +: 8];
    hsel = word[16*bus.address[1] +: 16];
    case (bus.MemOp)
      MEM_BYTE: bus.dout = bus.MemEXT ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
      MEM_HALF: bus.dout = bus.MemEXT ? {{16{hsel[15]}}, hsel} : {16'h0, hsel};
      default:  bus.dout = word;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: memory as little-endian bytes, access legal iff inside 4 KiB and naturally aligned
  task automatic predict(input logic we, input logic [1:0] op, input logic ext,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int n;
    logic [31:0] v;
    n = (op == MEM_BYTE) ? 1 : (op == MEM_HALF) ? 2 : 4;
    e.fault   = (op == 2'b11) || (addr >= 32'd4096) || ((addr % n) != 0);
    e.badaddr = e.fault ? addr : 32'h0;
    e.rdata   = 32'h0;
    e.due     = 0;
    if (!e.fault) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
        if (ext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e.rdata = v;
      end
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    neg_cnt <= neg_cnt + 1;
    if (bus.DMWr)    dmwr_cyc <= dmwr_cyc + 1;
    if (bus.MemRead) memread_cyc <= memread_cyc + 1;
    if (bus.rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      last_fault   <= bus.rsp_fault;
      last_rdata   <= bus.rsp_rdata;
      last_badaddr <= bus.rsp_badaddr;
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_fault", {31'h0, bus.rsp_fault}, {31'h0, e.fault});
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_badaddr", bus.rsp_badaddr, e.badaddr);
        chk("rsp_latency", neg_cnt + 1, e.due);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] op, input logic ext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk); #1;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_ext   = ext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    predict(we, op, ext, addr, wdata, e);
    e.due = neg_cnt + (e.fault ? 1 : 2);
    q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, m0, r0;
    logic [31:0] addr, saved;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_op    = MEM_BYTE;
    bus.req_ext   = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    rst = 1'b1;
    #3;
    chk("reset_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("reset_strobes", {30'h0, bus.DMWr, bus.MemRead}, 32'h0);
    chk("reset_address", bus.address, 32'h0);
    chk("reset_din", bus.din, 32'h0);
    chk("reset_memop", {29'h0, bus.MemOp, bus.MemEXT}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);

    // Store then load a word; exactly one write strobe cycle
    d0 = dmwr_cyc;
    issue(1'b1, MEM_WORD, 1'b0, 32'h10, 32'h1234_5678);
    drain();
    chk("store_dmwr_cycles", 32'(dmwr_cyc - d0), 32'd1);
    issue(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0);
    drain();
    chk("load_word", last_rdata, 32'h1234_5678);

    issue(1'b0, MEM_BYTE, 1'b1, 32'h13, 32'h0);
    drain();
    chk("load_byte_sext", last_rdata, 32'h0000_0012);
    issue(1'b0, MEM_BYTE, 1'b0, 32'h13, 32'h0);
    drain();
    chk("load_byte_zext", last_rdata, 32'h0000_0012);
    issue(1'b1, MEM_BYTE, 1'b0, 32'h13, 32'h0000_00F0);
    issue(1'b0, MEM_BYTE, 1'b1, 32'h13, 32'h0);
    drain();
    chk("load_byte_neg", last_rdata, 32'hFFFF_FFF0);

    // Misaligned half: fault without touching memory
    d0 = dmwr_cyc; m0 = memread_cyc;
    issue(1'b0, MEM_HALF, 1'b1, 32'h11, 32'h0);
    drain();
    chk("half_fault", {31'h0, last_fault}, 32'h1);
    chk("half_badaddr", last_badaddr, 32'h11);
    chk("half_no_strobes", 32'((dmwr_cyc - d0) + (memread_cyc - m0)), 32'd0);

    d0 = dmwr_cyc;
    issue(1'b1, MEM_WORD, 1'b0, 32'h1000, 32'hCAFE_BABE);
    issue(1'b1, 2'b11, 1'b0, 32'h14, 32'hCAFE_BABE);
    drain();
    chk("fault_no_write", 32'(dmwr_cyc - d0), 32'd0);
    chk("mem_unchanged", mem[4], 32'hF034_5678);

    // Boundary of the window
    issue(1'b0, MEM_BYTE, 1'b0, 32'hFFF, 32'h0);
    issue(1'b0, MEM_HALF, 1'b0, 32'hFFF, 32'h0);
    issue(1'b0, MEM_WORD, 1'b0, 32'hFFF, 32'h0);
    issue(1'b1, MEM_WORD, 1'b0, 32'hFFC, 32'hA5A5_0F0F);
    issue(1'b0, MEM_WORD, 1'b0, 32'hFFC, 32'h0);
    issue(1'b0, MEM_BYTE, 1'b0, 32'h1000, 32'h0);
    issue(1'b0, MEM_BYTE, 1'b0, 32'hFFFF_FFFF, 32'h0);
    drain();

    // A request pulsed while busy is dropped
    r0 = rsp_cnt;
    issue(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0);
    bus.req_addr  = 32'h40;
    bus.req_op    = MEM_WORD;
    bus.req_we    = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain();
    @(negedge clk); @(negedge clk);
    chk("busy_pulse_one_rsp", 32'(rsp_cnt - r0), 32'd1);

    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'hFFC + 32'($urandom_range(0, 7));
      else             addr = 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            addr, $urandom);
    end
    drain();

    // Reset in the first half of a store's access cycle
    saved = ref_word(32);
    r0 = rsp_cnt;
    @(negedge clk); #1;
    bus.req_we    = 1'b1;
    bus.req_op    = MEM_WORD;
    bus.req_addr  = 32'h20;
    bus.req_wdata = ~saved;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("abort_dmwr_before", {31'h0, bus.DMWr}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_dmwr_drop", {31'h0, bus.DMWr}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_release", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("abort_ready_next", {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk); @(negedge clk); #1;
    chk("abort_mem_unchanged", mem[8], saved);
    chk("abort_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
